// File: rtl/decode_instr_queue_if.sv
// Fetch-to-decode handshake bundle: fetch pushes instruction/PC pairs, decode sees the head entry.
// The master modport is the fetch/decode control side; the slave modport is the queue.
interface decode_instr_queue_if #(
  parameter int XLEN = 64
);
  logic            FlushD;
  logic            StallD;
  logic [31:0]     InstrF;
  logic [XLEN-1:0] PCF;
  logic            InstrValidF;
  logic            InstrReadyF;
  logic [31:0]     InstrD;
  logic [XLEN-1:0] PCD;
  logic            InstrValidD;

  modport master (
    output FlushD, StallD, InstrF, PCF, InstrValidF,
    input  InstrReadyF, InstrD, PCD, InstrValidD
  );

  modport slave (
    input  FlushD, StallD, InstrF, PCF, InstrValidF,
    output InstrReadyF, InstrD, PCD, InstrValidD
  );
endinterface

// File: rtl/decode_instr_queue.sv
// Instruction queue between fetch and decode; shows the head entry, or a NOP bubble when empty.
// Define DECODE_QUEUE_BYPASS_EN to forward InstrF straight to decode when the queue is empty.
module decode_instr_queue #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 2
) (
  input logic                  clk,
  input logic                  reset,
  decode_instr_queue_if.slave  q
);
  localparam int            PW        = $clog2(DEPTH);
  localparam logic [31:0]   NOP       = 32'h0000_0013;
  localparam logic [PW:0]   CNT_DEPTH = (PW+1)'(DEPTH);
  localparam logic [PW:0]   CNT_ONE   = (PW+1)'(1);
  localparam logic [PW-1:0] PTR_ONE   = PW'(1);

  logic [31:0]     instr_mem [DEPTH];
  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [PW:0]     count;
  logic            head_vld;
  logic            bypass_take;
  logic            push;
  logic            pop;

  assign head_vld      = (count != '0);
  assign q.InstrReadyF = (count < CNT_DEPTH);

`ifdef DECODE_QUEUE_BYPASS_EN
  // An empty queue hands InstrF to decode directly; if decode takes it, it is never stored.
  assign bypass_take = ~head_vld & q.InstrValidF & ~q.StallD & ~q.FlushD;
`else
  assign bypass_take = 1'b0;
`endif

  assign push = q.InstrValidF & q.InstrReadyF & ~q.FlushD & ~bypass_take;
  assign pop  = head_vld & ~q.StallD & ~q.FlushD;

  always_comb begin
    q.InstrValidD = head_vld;
    q.InstrD      = NOP;
    q.PCD         = '0;
    if (head_vld) begin
      q.InstrD = instr_mem[rd_ptr];
      q.PCD    = pc_mem[rd_ptr];
    end
`ifdef DECODE_QUEUE_BYPASS_EN
    else if (q.InstrValidF) begin
      q.InstrValidD = 1'b1;
      q.InstrD      = q.InstrF;
      q.PCD         = q.PCF;
    end
`endif
  end

  // Entry storage carries no reset; only pointers and occupancy define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr] <= q.InstrF;
      pc_mem[wr_ptr]    <= q.PCF;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (q.FlushD) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: tb/tb_decode_instr_queue.sv
// Self-checking bench for decode_instr_queue: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_decode_instr_queue;
  localparam int XLEN  = 64;
  localparam int DEPTH = 2;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp  = 0;
  int   n_fail = 0;

  decode_instr_queue_if #(.XLEN(XLEN)) ifc ();

  decode_instr_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .q     (ifc)
  );

  always #5 clk = ~clk;

  // Reference model: the queue contents as a list of {instr, pc}.
  logic [31+XLEN:0] mq[$];

  function automatic logic exp_ready();
    return mq.size() < DEPTH;
  endfunction

  function automatic logic exp_valid();
`ifdef DECODE_QUEUE_BYPASS_EN
    if (mq.size() == 0 && ifc.InstrValidF) return 1'b1;
`endif
    return mq.size() != 0;
  endfunction

  function automatic logic [31:0] exp_instr();
    logic [31+XLEN:0] e;
    if (mq.size() != 0) begin
      e = mq[0];
      return e[31+XLEN:XLEN];
    end
`ifdef DECODE_QUEUE_BYPASS_EN
    if (ifc.InstrValidF) return ifc.InstrF;
`endif
    return NOP;
  endfunction

  function automatic logic [XLEN-1:0] exp_pc();
    logic [31+XLEN:0] e;
    if (mq.size() != 0) begin
      e = mq[0];
      return e[XLEN-1:0];
    end
`ifdef DECODE_QUEUE_BYPASS_EN
    if (ifc.InstrValidF) return ifc.PCF;
`endif
    return '0;
  endfunction

  // Called just after the negedge: set inputs and let combinational outputs settle.
  task automatic drive(input logic vf, input logic [31:0] ins, input logic [XLEN-1:0] pc,
                       input logic st, input logic fl);
    ifc.InstrValidF = vf;
    ifc.InstrF      = ins;
    ifc.PCF         = pc;
    ifc.StallD      = st;
    ifc.FlushD      = fl;
    #1;
  endtask

  // Advance the model by the queue rules using the inputs now applied, then clock once.
  task automatic clk_step();
    int sz;
    logic pop_e, push_e;
    logic [31+XLEN:0] dummy;
    sz = mq.size();
    if (ifc.FlushD) begin
      mq.delete();
    end else begin
      pop_e  = (sz != 0) && !ifc.StallD;
      push_e = ifc.InstrValidF && (sz < DEPTH);
`ifdef DECODE_QUEUE_BYPASS_EN
      if (sz == 0 && !ifc.StallD) push_e = 1'b0;
`endif
      if (pop_e) dummy = mq.pop_front();
      if (push_e) mq.push_back({ifc.InstrF, ifc.PCF});
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, '0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    mq.delete();
    #1;
    n_cmp++; if (ifc.InstrValidD !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", ifc.InstrValidD); end
    n_cmp++; if (ifc.InstrD !== NOP) begin n_fail++; $display("FAIL reset_instr got %h want %h", ifc.InstrD, NOP); end
    n_cmp++; if (ifc.PCD !== '0) begin n_fail++; $display("FAIL reset_pc got %h want 0", ifc.PCD); end
    n_cmp++; if (ifc.InstrReadyF !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", ifc.InstrReadyF); end
  endtask

  task automatic test_single_push();
    drive(1'b1, 32'h0050_0093, 64'h8000_0000, 1'b0, 1'b0);
`ifdef DECODE_QUEUE_BYPASS_EN
    n_cmp++; if (ifc.InstrD !== 32'h0050_0093) begin n_fail++; $display("FAIL single_bypass_instr got %h want 00500093", ifc.InstrD); end
    n_cmp++; if (ifc.InstrValidD !== 1'b1) begin n_fail++; $display("FAIL single_bypass_valid got %b want 1", ifc.InstrValidD); end
    clk_step();
    idle();
    n_cmp++; if (ifc.InstrValidD !== 1'b0) begin n_fail++; $display("FAIL single_bypass_stored got %b want 0", ifc.InstrValidD); end
`else
    n_cmp++; if (ifc.InstrValidD !== 1'b0) begin n_fail++; $display("FAIL single_same_cycle_valid got %b want 0", ifc.InstrValidD); end
    clk_step();
    idle();
    n_cmp++; if (ifc.InstrD !== 32'h0050_0093) begin n_fail++; $display("FAIL single_instr got %h want 00500093", ifc.InstrD); end
    n_cmp++; if (ifc.PCD !== 64'h8000_0000) begin n_fail++; $display("FAIL single_pc got %h want 80000000", ifc.PCD); end
    n_cmp++; if (ifc.InstrValidD !== 1'b1) begin n_fail++; $display("FAIL single_valid got %b want 1", ifc.InstrValidD); end
    clk_step();
    n_cmp++; if (ifc.InstrValidD !== 1'b0) begin n_fail++; $display("FAIL single_drain got %b want 0", ifc.InstrValidD); end
`endif
    n_cmp++; if (ifc.InstrD !== NOP) begin n_fail++; $display("FAIL single_nop got %h want %h", ifc.InstrD, NOP); end
  endtask

  task automatic test_stall_fill();
    drive(1'b1, 32'hAAAA_000A, 64'h100, 1'b1, 1'b0);
    clk_step();
    drive(1'b1, 32'hBBBB_000B, 64'h104, 1'b1, 1'b0);
    n_cmp++; if (ifc.InstrReadyF !== 1'b1) begin n_fail++; $display("FAIL fill_ready1 got %b want 1", ifc.InstrReadyF); end
    clk_step();
    drive(1'b1, 32'hCCCC_000C, 64'h108, 1'b1, 1'b0);
    n_cmp++; if (ifc.InstrReadyF !== 1'b0) begin n_fail++; $display("FAIL fill_full got %b want 0", ifc.InstrReadyF); end
    n_cmp++; if (ifc.InstrD !== 32'hAAAA_000A) begin n_fail++; $display("FAIL fill_head got %h want AAAA000A", ifc.InstrD); end
    clk_step();
    drive(1'b0, 32'h0, '0, 1'b0, 1'b0);
    n_cmp++; if (ifc.InstrD !== 32'hAAAA_000A) begin n_fail++; $display("FAIL drain_a got %h want AAAA000A", ifc.InstrD); end
    n_cmp++; if (ifc.PCD !== 64'h100) begin n_fail++; $display("FAIL drain_a_pc got %h want 100", ifc.PCD); end
    clk_step();
    n_cmp++; if (ifc.InstrD !== 32'hBBBB_000B) begin n_fail++; $display("FAIL drain_b got %h want BBBB000B", ifc.InstrD); end
    n_cmp++; if (ifc.PCD !== 64'h104) begin n_fail++; $display("FAIL drain_b_pc got %h want 104", ifc.PCD); end
    clk_step();
    n_cmp++; if (ifc.InstrValidD !== 1'b0 || ifc.InstrD !== NOP) begin n_fail++; $display("FAIL drain_end got %b/%h want 0/%h", ifc.InstrValidD, ifc.InstrD, NOP); end
  endtask

  task automatic test_full_pop_push();
    drive(1'b1, 32'h1111_0001, 64'h200, 1'b1, 1'b0);
    clk_step();
    drive(1'b1, 32'h2222_0002, 64'h204, 1'b1, 1'b0);
    clk_step();
    drive(1'b1, 32'h3333_0003, 64'h208, 1'b0, 1'b0);
    n_cmp++; if (ifc.InstrReadyF !== 1'b0) begin n_fail++; $display("FAIL fullpop_refuse got %b want 0", ifc.InstrReadyF); end
    clk_step();
    drive(1'b1, 32'h3333_0003, 64'h208, 1'b1, 1'b0);
    n_cmp++; if (ifc.InstrD !== 32'h2222_0002) begin n_fail++; $display("FAIL fullpop_head got %h want 22220002", ifc.InstrD); end
    n_cmp++; if (ifc.InstrReadyF !== 1'b1) begin n_fail++; $display("FAIL fullpop_ready got %b want 1", ifc.InstrReadyF); end
    clk_step();
    drive(1'b0, 32'h0, '0, 1'b0, 1'b0);
    n_cmp++; if (ifc.InstrReadyF !== 1'b0) begin n_fail++; $display("FAIL fullpop_refull got %b want 0", ifc.InstrReadyF); end
    clk_step();
    n_cmp++; if (ifc.InstrD !== 32'h3333_0003) begin n_fail++; $display("FAIL fullpop_c got %h want 33330003", ifc.InstrD); end
    clk_step();
    n_cmp++; if (ifc.InstrValidD !== 1'b0) begin n_fail++; $display("FAIL fullpop_empty got %b want 0", ifc.InstrValidD); end
  endtask

  task automatic test_flush();
    drive(1'b1, 32'h4444_0004, 64'h300, 1'b1, 1'b0);
    clk_step();
    drive(1'b1, 32'h5555_0005, 64'h304, 1'b1, 1'b0);
    clk_step();
    drive(1'b1, 32'h6666_0006, 64'h308, 1'b1, 1'b1);
    n_cmp++; if (ifc.InstrD !== 32'h4444_0004 || ifc.InstrValidD !== 1'b1) begin n_fail++; $display("FAIL flush_cycle_head got %b/%h want 1/44440004", ifc.InstrValidD, ifc.InstrD); end
    clk_step();
    idle();
    n_cmp++; if (ifc.InstrValidD !== 1'b0) begin n_fail++; $display("FAIL flush_valid got %b want 0", ifc.InstrValidD); end
    n_cmp++; if (ifc.InstrD !== NOP || ifc.PCD !== '0) begin n_fail++; $display("FAIL flush_nop got %h/%h want %h/0", ifc.InstrD, ifc.PCD, NOP); end
    n_cmp++; if (ifc.InstrReadyF !== 1'b1) begin n_fail++; $display("FAIL flush_ready got %b want 1", ifc.InstrReadyF); end
    clk_step();
    n_cmp++; if (ifc.InstrValidD !== 1'b0) begin n_fail++; $display("FAIL flush_dropped got %b want 0", ifc.InstrValidD); end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 32'h7777_0007, 64'h400, 1'b1, 1'b0);
    clk_step();
    idle();
    n_cmp++; if (ifc.InstrValidD !== 1'b1) begin n_fail++; $display("FAIL areset_pre got %b want 1", ifc.InstrValidD); end
    #1 reset = 1'b1;
    #1;
    mq.delete();
    n_cmp++; if (ifc.InstrValidD !== 1'b0 || ifc.InstrD !== NOP || ifc.PCD !== '0) begin n_fail++; $display("FAIL areset_now got %b/%h/%h want 0/%h/0", ifc.InstrValidD, ifc.InstrD, ifc.PCD, NOP); end
    @(negedge clk);
    reset = 1'b0;
    drive(1'b1, 32'h8888_0008, 64'h500, 1'b1, 1'b0);
    clk_step();
    idle();
    n_cmp++; if (ifc.InstrD !== 32'h8888_0008 || ifc.PCD !== 64'h500) begin n_fail++; $display("FAIL areset_first got %h/%h want 88880008/500", ifc.InstrD, ifc.PCD); end
    clk_step();
  endtask

  task automatic test_random();
    logic [XLEN-1:0] pc;
    pc = 64'h8000_1000;
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 3) != 0), $urandom, pc, ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 19) == 0));
      n_cmp++; if (ifc.InstrValidD !== exp_valid()) begin n_fail++; $display("FAIL rnd_valid[%0d] got %b want %b", i, ifc.InstrValidD, exp_valid()); end
      n_cmp++; if (ifc.InstrD !== exp_instr()) begin n_fail++; $display("FAIL rnd_instr[%0d] got %h want %h", i, ifc.InstrD, exp_instr()); end
      n_cmp++; if (ifc.PCD !== exp_pc()) begin n_fail++; $display("FAIL rnd_pc[%0d] got %h want %h", i, ifc.PCD, exp_pc()); end
      n_cmp++; if (ifc.InstrReadyF !== exp_ready()) begin n_fail++; $display("FAIL rnd_ready[%0d] got %b want %b", i, ifc.InstrReadyF, exp_ready()); end
      clk_step();
      pc = pc + 64'd4;
    end
  endtask

  initial begin
    reset = 1'b0;
    @(negedge clk);
    test_reset();
    test_single_push();
    test_stall_fill();
    test_full_pop_push();
    test_flush();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule
